enigma_step_ctrl: RTL and testbench
===================================

// Module: enigma_step_ctrl
// PURPOSE
//  Keypress sequencer that sits directly upstream of the rotor chain (right/middle/left rotors + reflector).
//  Accepts one plaintext letter, generates rotate strobes for three rotors with Enigma double-step rules,
//  drives the one-hot letter into the chain and waits for the combinational path to settle.
//  It then captures the one-hot lamp result, encodes it to a 5-bit letter and offers it on a valid/ready output.
// PARAMETERS
//  PULSE_CYCLES   2   cycles each asserted rotate strobe stays high (>=1)
//  SETTLE_CYCLES  4   cycles between strobe fall and lamp capture (>=1)
// PORTS
//  clk         in   1   single clock, all state on posedge
//  reset       in   1   asynchronous, active-high; clears all state
//  key_valid   in   1   key_letter valid
//  key_letter  in   5   plaintext letter, A=0 .. Z=25
//  key_ready   out  1   high only in IDLE
//  notch_r     in   1   right-rotor notch (rotor at turnover position)
//  notch_m     in   1   middle-rotor notch
//  rotate_r    out  1   right-rotor step strobe (rotor steps on rising edge)
//  rotate_m    out  1   middle-rotor step strobe
//  rotate_l    out  1   left-rotor step strobe
//  path_out    out  26  one-hot letter driven into right rotor input
//  lamp_in     in   26  one-hot result returned from rotor chain
//  out_valid   out  1   result valid
//  out_letter  out  5   ciphertext letter
//  out_err     out  1   result invalid (bad key or lamp_in not one-hot)
//  out_ready   in   1   downstream accepts result
// BEHAVIOUR
//  - Reset: state IDLE; key_ready=1 after reset release; rotate_*=0, path_out=0, out_valid=0,
//    out_letter=0, out_err=0. Reset does not return rotors to A; rotor position is owned by the rotors.
//  - All outputs registered. States: IDLE -> STEP -> SETTLE -> CAPTURE -> OUT -> IDLE.
//  - IDLE: key_ready=1. Accept on key_valid&key_ready (cycle T): latch key_letter, latch notch_r/notch_m
//    (pre-step values), go STEP.
//  - Step decision from latched notches: rotate_r always; rotate_m if notch_r | notch_m (double step);
//    rotate_l if notch_m.
//  - STEP: selected strobes high for cycles T+1 .. T+PULSE_CYCLES; exactly one rising edge per strobe
//    per key. Unselected strobes stay 0.
//  - SETTLE: all strobes 0; SETTLE_CYCLES cycles; path_out = one-hot(key) from T+1 through CAPTURE.
//  - CAPTURE (1 cycle): sample lamp_in; out_letter = index of set bit; out_err=1 and out_letter=31 if
//    lamp_in has zero or >1 bits set. path_out returns to 0 on leaving CAPTURE.
//  - OUT: out_valid=1, letter/err held stable until out_valid&out_ready; then IDLE next cycle.
//  - Latency accept -> out_valid = PULSE_CYCLES + SETTLE_CYCLES + 2 cycles (8 at defaults).
//  - key_letter 26..31: accepted, no strobes, path_out=0, SETTLE skipped; result out_err=1, out_letter=31.
//  - key_valid while busy: ignored (key_ready=0), no buffering.
//  - Counter: one down-counter, width clog2(max(PULSE_CYCLES,SETTLE_CYCLES))+1, reloaded on state entry;
//    no wrap beyond reload.
//  - Reset mid-operation: strobes drop to 0 asynchronously; an in-flight key is lost; a partial strobe
//    may already have stepped a rotor (accepted).
// STRUCTURE
//  - enigma_pkg: LETTER_W=5, NUM_LETTERS=26, letter constants A..Z, LETTER_INVALID=5'd31, state enum.
//  - Sub-module onehot_to_letter: combinational 26-bit one-hot -> {err, letter[4:0]}; used in CAPTURE.
// TESTING
//  1. Reset held 3 cycles -> all outputs 0 (key_ready=1 after release); no rotate edge during/after.
//  2. key A, notches 0, lamp_in=1<<4 -> only rotate_r high T+1..T+2; path_out=1<<0;
//     out_valid at T+8 with letter 4, err 0.
//  3. key C, notch_r=1, notch_m=0 -> rotate_r and rotate_m pulse, rotate_l stays 0.
//  4. key C, notch_m=1 (double step) -> rotate_r, rotate_m, rotate_l all pulse exactly once.
//  5. lamp_in=0 then lamp_in=(1<<3)|(1<<7); key_letter=28 -> out_err=1, out_letter=31; no strobes for 28.
//  6. out_ready low 5 cycles with key_valid high -> out_valid/letter stable, key_ready=0;
//     reset asserted mid-STEP -> rotate_* 0 same cycle, IDLE.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma keypress sequencer.
// Letters are encoded A=0 .. Z=25; 31 marks an invalid result.
package enigma_pkg;

  localparam int LETTER_W    = 5;
  localparam int NUM_LETTERS = 26;

  localparam logic [LETTER_W-1:0] LTR_A = 5'd0;
  localparam logic [LETTER_W-1:0] LTR_B = 5'd1;
  localparam logic [LETTER_W-1:0] LTR_C = 5'd2;
  localparam logic [LETTER_W-1:0] LTR_D = 5'd3;
  localparam logic [LETTER_W-1:0] LTR_E = 5'd4;
  localparam logic [LETTER_W-1:0] LTR_F = 5'd5;
  localparam logic [LETTER_W-1:0] LTR_G = 5'd6;
  localparam logic [LETTER_W-1:0] LTR_H = 5'd7;
  localparam logic [LETTER_W-1:0] LTR_I = 5'd8;
  localparam logic [LETTER_W-1:0] LTR_J = 5'd9;
  localparam logic [LETTER_W-1:0] LTR_K = 5'd10;
  localparam logic [LETTER_W-1:0] LTR_L = 5'd11;
  localparam logic [LETTER_W-1:0] LTR_M = 5'd12;
  localparam logic [LETTER_W-1:0] LTR_N = 5'd13;
  localparam logic [LETTER_W-1:0] LTR_O = 5'd14;
  localparam logic [LETTER_W-1:0] LTR_P = 5'd15;
  localparam logic [LETTER_W-1:0] LTR_Q = 5'd16;
  localparam logic [LETTER_W-1:0] LTR_R = 5'd17;
  localparam logic [LETTER_W-1:0] LTR_S = 5'd18;
  localparam logic [LETTER_W-1:0] LTR_T = 5'd19;
  localparam logic [LETTER_W-1:0] LTR_U = 5'd20;
  localparam logic [LETTER_W-1:0] LTR_V = 5'd21;
  localparam logic [LETTER_W-1:0] LTR_W = 5'd22;
  localparam logic [LETTER_W-1:0] LTR_X = 5'd23;
  localparam logic [LETTER_W-1:0] LTR_Y = 5'd24;
  localparam logic [LETTER_W-1:0] LTR_Z = 5'd25;

  localparam logic [LETTER_W-1:0] LETTER_INVALID = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_SETTLE,
    S_CAPTURE,
    S_OUT
  } state_t;

  function automatic logic letter_ok(
    input logic [LETTER_W-1:0] l
  );
    return l <= LTR_Z;
  endfunction

  function automatic logic [NUM_LETTERS-1:0] letter_onehot(
    input logic [LETTER_W-1:0] l
  );
    logic [NUM_LETTERS-1:0] v;
    v = '0;
    if (letter_ok(l)) v[l] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_to_letter.sv
// Encodes the 26-bit lamp vector into a letter index.
// Flags err and returns 31 unless exactly one bit is set.
module onehot_to_letter
  import enigma_pkg::*;
(
  input  logic [NUM_LETTERS-1:0] lamp,
  output logic [LETTER_W-1:0]    letter,
  output logic                   err
);

  logic [LETTER_W-1:0] idx;
  logic [LETTER_W-1:0] ones;

  // Population count plus index of the (last) set bit.
  always_comb begin
    idx  = '0;
    ones = '0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (lamp[i]) begin
        idx  = LETTER_W'(i);
        ones = ones + 5'd1;
      end
    end
    err    = (ones != 5'd1);
    letter = err ? LETTER_INVALID : idx;
  end

endmodule

// File: rtl/enigma_step_ctrl.sv
// Keypress sequencer: rotor stepping, path drive, lamp capture.
// Every output is a register; reset only clears sequencer state.
module enigma_step_ctrl
  import enigma_pkg::*;
#(
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_valid,
  input  logic [LETTER_W-1:0]    key_letter,
  output logic                   key_ready,
  input  logic                   notch_r,
  input  logic                   notch_m,
  output logic                   rotate_r,
  output logic                   rotate_m,
  output logic                   rotate_l,
  output logic [NUM_LETTERS-1:0] path_out,
  input  logic [NUM_LETTERS-1:0] lamp_in,
  output logic                   out_valid,
  output logic [LETTER_W-1:0]    out_letter,
  output logic                   out_err,
  input  logic                   out_ready
);

  localparam int MAXC =
    (PULSE_CYCLES > SETTLE_CYCLES) ?
    PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(MAXC) + 1;

  localparam logic [CNT_W-1:0] P_LOAD =
    CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] S_LOAD =
    CNT_W'(SETTLE_CYCLES - 1);

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic                   bad_q, bad_n;
  logic                   sel_m_q, sel_m_n;
  logic                   sel_l_q, sel_l_n;
  logic                   key_ready_n;
  logic                   rot_r_n, rot_m_n, rot_l_n;
  logic [NUM_LETTERS-1:0] path_n;
  logic                   out_valid_n;
  logic [LETTER_W-1:0]    out_letter_n;
  logic                   out_err_n;

  logic [LETTER_W-1:0]    dec_letter;
  logic                   dec_err;
  logic                   accept;
  logic                   cnt_zero;

  onehot_to_letter u_dec (
    .lamp   (lamp_in),
    .letter (dec_letter),
    .err    (dec_err)
  );

  assign accept   = key_valid & key_ready;
  assign cnt_zero = (cnt == '0);

  // Next-state and next-output logic; everything holds by default.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    bad_n        = bad_q;
    sel_m_n      = sel_m_q;
    sel_l_n      = sel_l_q;
    rot_r_n      = rotate_r;
    rot_m_n      = rotate_m;
    rot_l_n      = rotate_l;
    path_n       = path_out;
    out_valid_n  = out_valid;
    out_letter_n = out_letter;
    out_err_n    = out_err;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_STEP;
          cnt_n   = P_LOAD;
          bad_n   = ~letter_ok(key_letter);
          sel_m_n = notch_r | notch_m;
          sel_l_n = notch_m;
          rot_r_n = ~bad_n;
          rot_m_n = ~bad_n & sel_m_n;
          rot_l_n = ~bad_n & sel_l_n;
          path_n  = letter_onehot(key_letter);
        end
      end
      S_STEP: begin
        rot_r_n = ~bad_q & ~cnt_zero;
        rot_m_n = ~bad_q & sel_m_q & ~cnt_zero;
        rot_l_n = ~bad_q & sel_l_q & ~cnt_zero;
        if (!cnt_zero) begin
          cnt_n = cnt - 1'b1;
        end else if (bad_q) begin
          state_n = S_CAPTURE;
          cnt_n   = '0;
        end else begin
          state_n = S_SETTLE;
          cnt_n   = S_LOAD;
        end
      end
      S_SETTLE: begin
        if (!cnt_zero) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = S_CAPTURE;
          cnt_n   = '0;
        end
      end
      S_CAPTURE: begin
        state_n      = S_OUT;
        path_n       = '0;
        out_valid_n  = 1'b1;
        out_err_n    = bad_q | dec_err;
        out_letter_n = out_err_n ? LETTER_INVALID
                                 : dec_letter;
      end
      S_OUT: begin
        if (out_ready) begin
          state_n     = S_IDLE;
          out_valid_n = 1'b0;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    key_ready_n = (state_n == S_IDLE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bad_q      <= 1'b0;
      sel_m_q    <= 1'b0;
      sel_l_q    <= 1'b0;
      key_ready  <= 1'b0;
      rotate_r   <= 1'b0;
      rotate_m   <= 1'b0;
      rotate_l   <= 1'b0;
      path_out   <= '0;
      out_valid  <= 1'b0;
      out_letter <= '0;
      out_err    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bad_q      <= bad_n;
      sel_m_q    <= sel_m_n;
      sel_l_q    <= sel_l_n;
      key_ready  <= key_ready_n;
      rotate_r   <= rot_r_n;
      rotate_m   <= rot_m_n;
      rotate_l   <= rot_l_n;
      path_out   <= path_n;
      out_valid  <= out_valid_n;
      out_letter <= out_letter_n;
      out_err    <= out_err_n;
    end
  end

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Directed bench for enigma_step_ctrl at default parameters.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_enigma_step_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [4:0]  key_letter;
  logic        key_ready;
  logic        notch_r;
  logic        notch_m;
  logic        rotate_r;
  logic        rotate_m;
  logic        rotate_l;
  logic [25:0] path_out;
  logic [25:0] lamp_in;
  logic        out_valid;
  logic [4:0]  out_letter;
  logic        out_err;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enigma_step_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_letter (key_letter),
    .key_ready  (key_ready),
    .notch_r    (notch_r),
    .notch_m    (notch_m),
    .rotate_r   (rotate_r),
    .rotate_m   (rotate_m),
    .rotate_l   (rotate_l),
    .path_out   (path_out),
    .lamp_in    (lamp_in),
    .out_valid  (out_valid),
    .out_letter (out_letter),
    .out_err    (out_err),
    .out_ready  (out_ready)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_strobes(
    input string tag,
    input logic  r,
    input logic  m,
    input logic  l
  );
    chk({tag, " rotate_r"}, 32'(rotate_r), 32'(r));
    chk({tag, " rotate_m"}, 32'(rotate_m), 32'(m));
    chk({tag, " rotate_l"}, 32'(rotate_l), 32'(l));
  endtask

  // Valid key: full 8-cycle timeline, then handshake.
  task automatic do_key(
    input string       tag,
    input logic [4:0]  k,
    input logic        nr,
    input logic        nm,
    input logic [25:0] lamp,
    input logic        em,
    input logic        el,
    input logic [4:0]  exp_letter,
    input logic        exp_err
  );
    logic [25:0] oh;
    oh = 26'd1 << k;
    chk({tag, " ready before"}, 32'(key_ready), 32'd1);
    key_valid  = 1'b1;
    key_letter = k;
    notch_r    = nr;
    notch_m    = nm;
    lamp_in    = lamp;
    @(negedge clk);
    key_valid = 1'b0;
    notch_r   = 1'b0;
    notch_m   = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk_strobes(tag, c <= 2, em && c <= 2,
                  el && c <= 2);
      chk({tag, " path_out"}, 32'(path_out),
          (c <= 7) ? 32'(oh) : 32'd0);
      chk({tag, " out_valid"}, 32'(out_valid),
          32'(c == 8));
      chk({tag, " key_ready busy"}, 32'(key_ready),
          32'd0);
      if (c < 8) @(negedge clk);
    end
    chk({tag, " out_letter"}, 32'(out_letter),
        32'(exp_letter));
    chk({tag, " out_err"}, 32'(out_err), 32'(exp_err));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " valid drop"}, 32'(out_valid), 32'd0);
    chk({tag, " ready back"}, 32'(key_ready), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    key_valid  = 1'b0;
    key_letter = 5'd0;
    notch_r    = 1'b0;
    notch_m    = 1'b0;
    lamp_in    = '0;
    out_ready  = 1'b0;

    // 1. reset held three cycles
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_strobes("rst", 1'b0, 1'b0, 1'b0);
      chk("rst path_out", 32'(path_out), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_letter", 32'(out_letter), 32'd0);
      chk("rst out_err", 32'(out_err), 32'd0);
      chk("rst key_ready", 32'(key_ready), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post rst key_ready", 32'(key_ready), 32'd1);
    chk_strobes("post rst", 1'b0, 1'b0, 1'b0);
    chk("post rst out_valid", 32'(out_valid), 32'd0);

    // 2. plain step, lamp E
    do_key("keyA", 5'd0, 1'b0, 1'b0, 26'd1 << 4,
           1'b0, 1'b0, 5'd4, 1'b0);
    // 3. right notch steps the middle rotor
    do_key("keyC_nr", 5'd2, 1'b1, 1'b0, 26'd1 << 1,
           1'b1, 1'b0, 5'd1, 1'b0);
    // 4. middle notch: double step
    do_key("keyC_nm", 5'd2, 1'b0, 1'b1, 26'd1 << 25,
           1'b1, 1'b1, 5'd25, 1'b0);
    // highest valid key, lamp A
    do_key("keyZ", 5'd25, 1'b0, 1'b0, 26'd1,
           1'b0, 1'b0, 5'd0, 1'b0);
    // 5. malformed lamp vectors
    do_key("lamp0", 5'd1, 1'b0, 1'b0, 26'd0,
           1'b0, 1'b0, 5'd31, 1'b1);
    do_key("lamp2", 5'd3, 1'b0, 1'b0,
           (26'd1 << 3) | (26'd1 << 7),
           1'b0, 1'b0, 5'd31, 1'b1);

    // out-of-range key: no strobes, no path
    key_valid  = 1'b1;
    key_letter = 5'd28;
    notch_r    = 1'b1;
    notch_m    = 1'b1;
    lamp_in    = 26'd1 << 5;
    @(negedge clk);
    key_valid = 1'b0;
    notch_r   = 1'b0;
    notch_m   = 1'b0;
    begin
      int budget;
      budget = 0;
      while (!out_valid && budget < 20) begin
        chk_strobes("key28", 1'b0, 1'b0, 1'b0);
        chk("key28 path_out", 32'(path_out), 32'd0);
        @(negedge clk);
        budget++;
      end
      chk("key28 timeout", 32'(out_valid), 32'd1);
    end
    chk("key28 out_letter", 32'(out_letter), 32'd31);
    chk("key28 out_err", 32'(out_err), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("key28 valid drop", 32'(out_valid), 32'd0);

    // 6. backpressure with key_valid held high
    key_valid  = 1'b1;
    key_letter = 5'd4;
    lamp_in    = 26'd1 << 10;
    @(negedge clk);
    for (int c = 1; c < 8; c++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp out_letter", 32'(out_letter), 32'd10);
      chk("bp out_err", 32'(out_err), 32'd0);
      chk("bp key_ready", 32'(key_ready), 32'd0);
      chk_strobes("bp", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    key_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp valid drop", 32'(out_valid), 32'd0);
    chk("bp ready back", 32'(key_ready), 32'd1);

    // reset asserted in the middle of STEP
    key_valid  = 1'b1;
    key_letter = 5'd5;
    notch_m    = 1'b1;
    lamp_in    = 26'd1 << 6;
    @(negedge clk);
    key_valid = 1'b0;
    notch_m   = 1'b0;
    chk_strobes("pre midrst", 1'b1, 1'b1, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_strobes("midrst", 1'b0, 1'b0, 1'b0);
    chk("midrst path_out", 32'(path_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst key_ready", 32'(key_ready), 32'd1);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_strobes("after midrst", 1'b0, 1'b0, 1'b0);
      chk("after midrst valid", 32'(out_valid), 32'd0);
    end

    // a fresh key still works after the interrupted one
    do_key("keyG", 5'd6, 1'b0, 1'b0, 26'd1 << 9,
           1'b0, 1'b0, 5'd9, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
